// File: rtl/s2_scheduler_pkg.sv
// Shared types and constants for the stage-2 convolution sequencer.
package s2_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int CHANS     = 3;
  localparam int K         = 3;
  localparam int NFILT     = 4;
  localparam int OUT_DIM   = ROWS - K + 1;
  localparam int N_WORDS   = ROWS * COLS * CHANS;
  localparam int N_POS     = OUT_DIM * OUT_DIM;
  localparam int N_RESULTS = NFILT * N_POS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_CONV,
    ST_DONE
  } state_t;

  // One tensor-builder write as it travels through the read-latency pipe.
  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] cha;
  } wr_coord_t;

  // Stage-1 BRAM layout: channel-major, then row, column fastest.
  function automatic logic [7:0] pack_addr(input logic [1:0] cha,
                                           input logic [2:0] row,
                                           input logic [2:0] col);
    return {cha, row, col};
  endfunction

endpackage

// File: rtl/s2_scheduler_if.sv
// Handshake and address bundle between the sequencer and its environment.
interface s2_scheduler_if;
  logic       start;
  logic       proc_stall;
  logic       busy;
  logic       done;
  logic       enable_read;
  logic [7:0] read_addr;
  logic       wr_valid;
  logic [2:0] row_addr;
  logic [2:0] col_addr;
  logic [1:0] cha_addr;
  logic       data_rdy;
  logic       proc_valid;
  logic [1:0] proc_dir;
  logic [5:0] proc_counter;
  logic [2:0] out_row;
  logic [2:0] out_col;

  // Environment side: issues start and back-pressure, observes the rest.
  modport master (
    output start, proc_stall,
    input  busy, done, enable_read, read_addr, wr_valid, row_addr, col_addr,
           cha_addr, data_rdy, proc_valid, proc_dir, proc_counter, out_row, out_col
  );

  // Sequencer side.
  modport slave (
    input  start, proc_stall,
    output busy, done, enable_read, read_addr, wr_valid, row_addr, col_addr,
           cha_addr, data_rdy, proc_valid, proc_dir, proc_counter, out_row, out_col
  );
endinterface

// File: rtl/s2_lat_pipe.sv
// Delay line that re-times read coordinates to match BRAM read latency.
module s2_lat_pipe
  import s2_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  wr_coord_t din,
  output wr_coord_t dout
);

  wr_coord_t stage_q [LAT];

  // Shift coordinates one stage per cycle; reset flushes all pending writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[LAT-1];

endmodule

// File: rtl/s2_scheduler.sv
// Stage-2 sequencer: loads the 8x8x3 tensor from BRAM, then walks
// 4 filters over the 6x6 output grid, with stall back-pressure.
module s2_scheduler
  import s2_pkg::*;
#(
  parameter int BRAM_LAT = 1  // 1 or 2
) (
  input logic          clk,
  input logic          rst,
  s2_scheduler_if.slave bus
);

  state_t     state_q,    state_d;
  logic [2:0] ld_row_q,   ld_row_d;
  logic [2:0] ld_col_q,   ld_col_d;
  logic [1:0] ld_cha_q,   ld_cha_d;
  logic [1:0] drain_q,    drain_d;
  logic [5:0] pos_q,      pos_d;
  logic [2:0] orow_q,     orow_d;
  logic [2:0] ocol_q,     ocol_d;
  logic [1:0] dir_q,      dir_d;
  logic       data_rdy_q, data_rdy_d;

  logic      enable_read;
  logic      proc_valid;
  logic      done;
  wr_coord_t rd_coord;
  wr_coord_t wr_coord;

  logic load_last;
  assign load_last = (ld_cha_q == 2'(CHANS - 1)) && (ld_row_q == 3'(ROWS - 1)) &&
                     (ld_col_q == 3'(COLS - 1));

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ld_row_q   <= '0;
      ld_col_q   <= '0;
      ld_cha_q   <= '0;
      drain_q    <= '0;
      pos_q      <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      dir_q      <= '0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_row_q   <= ld_row_d;
      ld_col_q   <= ld_col_d;
      ld_cha_q   <= ld_cha_d;
      drain_q    <= drain_d;
      pos_q      <= pos_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      dir_q      <= dir_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  // Next-state, counter stepping and strobes; counters return to 0 when a phase ends.
  always_comb begin
    state_d     = state_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    ld_cha_d    = ld_cha_q;
    drain_d     = drain_q;
    pos_d       = pos_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    dir_d       = dir_q;
    data_rdy_d  = data_rdy_q;
    enable_read = 1'b0;
    proc_valid  = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_LOAD;
          data_rdy_d = 1'b0;
        end
      end

      ST_LOAD: begin
        enable_read = 1'b1;
        if (load_last) begin
          state_d  = ST_DRAIN;
          ld_col_d = '0;
          ld_row_d = '0;
          ld_cha_d = '0;
        end else if (ld_col_q == 3'(COLS - 1)) begin
          ld_col_d = '0;
          if (ld_row_q == 3'(ROWS - 1)) begin
            ld_row_d = '0;
            ld_cha_d = ld_cha_q + 2'd1;
          end else begin
            ld_row_d = ld_row_q + 3'd1;
          end
        end else begin
          ld_col_d = ld_col_q + 3'd1;
        end
      end

      // Wait out the read latency so the last write lands before compute starts.
      ST_DRAIN: begin
        if (drain_q == 2'(BRAM_LAT - 1)) begin
          state_d    = ST_CONV;
          drain_d    = '0;
          data_rdy_d = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end

      ST_CONV: begin
        if (!bus.proc_stall) begin
          proc_valid = 1'b1;
          if (pos_q == 6'(N_POS - 1)) begin
            pos_d  = '0;
            orow_d = '0;
            ocol_d = '0;
            if (dir_q == 2'(NFILT - 1)) begin
              dir_d   = '0;
              state_d = ST_DONE;
            end else begin
              dir_d = dir_q + 2'd1;
            end
          end else begin
            pos_d = pos_q + 6'd1;
            // Row/column tracked by carry instead of dividing the position index.
            if (ocol_q == 3'(OUT_DIM - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + 3'd1;
            end else begin
              ocol_d = ocol_q + 3'd1;
            end
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_coord = '{valid: enable_read, row: ld_row_q, col: ld_col_q, cha: ld_cha_q};

  s2_lat_pipe #(.LAT(BRAM_LAT)) u_lat_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_coord),
    .dout (wr_coord)
  );

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done;
  assign bus.enable_read  = enable_read;
  assign bus.read_addr    = pack_addr(ld_cha_q, ld_row_q, ld_col_q);
  assign bus.wr_valid     = wr_coord.valid;
  assign bus.row_addr     = wr_coord.row;
  assign bus.col_addr     = wr_coord.col;
  assign bus.cha_addr     = wr_coord.cha;
  assign bus.data_rdy     = data_rdy_q;
  assign bus.proc_valid   = proc_valid;
  assign bus.proc_dir     = dir_q;
  assign bus.proc_counter = pos_q;
  assign bus.out_row      = orow_q;
  assign bus.out_col      = ocol_q;

endmodule

// File: tb/tb_s2_scheduler.sv
// Randomized self-checking bench for s2_scheduler with BRAM_LAT 1 and 2.
module tb_s2_scheduler;
  import s2_pkg::*;

  logic clk;
  logic rst;
  logic sel;          // 0: drive/observe the LAT=1 instance, 1: the LAT=2 instance
  logic start_drv;
  logic stall_drv;
  int   checks;
  int   errors;

  s2_scheduler_if bus1 ();
  s2_scheduler_if bus2 ();

  s2_scheduler #(.BRAM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  s2_scheduler #(.BRAM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus1.start      = sel ? 1'b0 : start_drv;
  assign bus1.proc_stall = sel ? 1'b0 : stall_drv;
  assign bus2.start      = sel ? start_drv : 1'b0;
  assign bus2.proc_stall = sel ? stall_drv : 1'b0;

  logic       o_busy, o_done, o_en, o_wr, o_rdy, o_pv;
  logic [7:0] o_addr;
  logic [2:0] o_row, o_col, o_orow, o_ocol;
  logic [1:0] o_cha, o_dir;
  logic [5:0] o_cnt;

  assign o_busy = sel ? bus2.busy         : bus1.busy;
  assign o_done = sel ? bus2.done         : bus1.done;
  assign o_en   = sel ? bus2.enable_read  : bus1.enable_read;
  assign o_addr = sel ? bus2.read_addr    : bus1.read_addr;
  assign o_wr   = sel ? bus2.wr_valid     : bus1.wr_valid;
  assign o_row  = sel ? bus2.row_addr     : bus1.row_addr;
  assign o_col  = sel ? bus2.col_addr     : bus1.col_addr;
  assign o_cha  = sel ? bus2.cha_addr     : bus1.cha_addr;
  assign o_rdy  = sel ? bus2.data_rdy     : bus1.data_rdy;
  assign o_pv   = sel ? bus2.proc_valid   : bus1.proc_valid;
  assign o_dir  = sel ? bus2.proc_dir     : bus1.proc_dir;
  assign o_cnt  = sel ? bus2.proc_counter : bus1.proc_counter;
  assign o_orow = sel ? bus2.out_row      : bus1.out_row;
  assign o_ocol = sel ? bus2.out_col      : bus1.out_col;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full operation: start at cycle 0, then compare every cycle against the model.
  // stall_mode: 0 none, 1 five stalls at result (dir 1, pos 20), 2 random.
  task automatic run_op(input bit use2, input int stall_mode, input int ex0, input int ex1,
                        input int abort_cyc, input string name);
    int lat, r, spec_stall, nstall, done_cyc, seen_done, rd_cnt, wr_cnt, res_cnt, done_cnt, d, pos;
    int data_q[$];
    int due_q[$];
    bit stall_b, in_conv, exp_wr, exp_load, finished, aborted;
    lat = use2 ? 2 : 1;
    r = 0; spec_stall = 0; nstall = 0; done_cyc = -1; seen_done = -1;
    rd_cnt = 0; wr_cnt = 0; res_cnt = 0; done_cnt = 0;
    finished = 0; aborted = 0;
    sel = use2;
    @(negedge clk);
    start_drv = 1'b1;
    stall_drv = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == abort_cyc) begin
        start_drv = 1'b0;
        stall_drv = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_en, o_wr, o_rdy, o_pv} !== 6'b0) begin
          errors++;
          $display("FAIL %s abort_outputs: got busy/done/en/wr/rdy/pv=%b, need 000000", name,
                   {o_busy, o_done, o_en, o_wr, o_rdy, o_pv});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          checks++;
          if ({o_busy, o_done, o_rdy} !== 3'b0) begin
            errors++;
            $display("FAIL %s post_abort_idle: got busy/done/rdy=%b, need 000", name,
                     {o_busy, o_done, o_rdy});
          end
        end
        aborted = 1;
        break;
      end
      start_drv = (n == ex0) || (n == ex1);
      in_conv = (n > 192 + lat) && (r < N_RESULTS);
      stall_b = 1'b0;
      if (stall_mode == 1) begin
        if (in_conv && r == N_POS + 20 && spec_stall < 5) begin
          stall_b = 1'b1;
          spec_stall++;
        end
      end else if (stall_mode == 2) begin
        stall_b = ($urandom_range(0, 3) == 0);
      end
      stall_drv = stall_b;
      if (in_conv && stall_b) nstall++;
      #1;

      exp_load = (n >= 1) && (n <= N_WORDS);
      if (o_en === 1'b1) rd_cnt++;
      checks++;
      if (o_en !== exp_load) begin
        errors++;
        $display("FAIL %s enable_read c%0d: got %b, need %b", name, n, o_en, exp_load);
      end
      if (exp_load) begin
        checks++;
        if (int'(o_addr) != n - 1) begin
          errors++;
          $display("FAIL %s read_addr c%0d: got %0d, need %0d", name, n, o_addr, n - 1);
        end
        data_q.push_back(n - 1 + 1000);   // BRAM model: word at addr holds addr+1000
        due_q.push_back(n + lat);
      end

      exp_wr = (due_q.size() > 0) && (due_q[0] == n);
      if (o_wr === 1'b1) wr_cnt++;
      checks++;
      if (o_wr !== exp_wr) begin
        errors++;
        $display("FAIL %s wr_valid c%0d: got %b, need %b", name, n, o_wr, exp_wr);
      end
      if (exp_wr) begin
        d = data_q.pop_front() - 1000;
        void'(due_q.pop_front());
        checks++;
        if (int'(o_cha) * ROWS * COLS + int'(o_row) * COLS + int'(o_col) != d) begin
          errors++;
          $display("FAIL %s wr_coord c%0d: got cha=%0d row=%0d col=%0d, need word %0d", name, n,
                   o_cha, o_row, o_col, d);
        end
      end

      if (o_pv === 1'b1) res_cnt++;
      checks++;
      if (o_pv !== (in_conv && !stall_b)) begin
        errors++;
        $display("FAIL %s proc_valid c%0d: got %b, need %b", name, n, o_pv, in_conv && !stall_b);
      end
      if (in_conv) begin
        pos = r % N_POS;
        checks++;
        if (int'(o_dir) != r / N_POS || int'(o_cnt) != pos ||
            int'(o_orow) != pos / OUT_DIM || int'(o_ocol) != pos % OUT_DIM) begin
          errors++;
          $display("FAIL %s indices c%0d: got dir=%0d cnt=%0d row=%0d col=%0d, need %0d %0d %0d %0d",
                   name, n, o_dir, o_cnt, o_orow, o_ocol, r / N_POS, pos, pos / OUT_DIM, pos % OUT_DIM);
        end
        if (!stall_b) begin
          r++;
          if (r == N_RESULTS) done_cyc = n + 1;
        end
      end

      if (o_done === 1'b1) begin
        done_cnt++;
        seen_done = n;
      end
      checks++;
      if (o_done !== (n == done_cyc)) begin
        errors++;
        $display("FAIL %s done c%0d: got %b, need %b", name, n, o_done, n == done_cyc);
      end
      checks++;
      if (o_busy !== (done_cyc < 0 || n <= done_cyc)) begin
        errors++;
        $display("FAIL %s busy c%0d: got %b, need %b", name, n, o_busy, done_cyc < 0 || n <= done_cyc);
      end
      checks++;
      if (o_rdy !== (n > 192 + lat)) begin
        errors++;
        $display("FAIL %s data_rdy c%0d: got %b, need %b", name, n, o_rdy, n > 192 + lat);
      end
      if (done_cyc >= 0 && n == done_cyc + 1) begin
        finished = 1;
        break;
      end
    end
    start_drv = 1'b0;
    stall_drv = 1'b0;
    if (aborted) begin
      $display("run %s: reset applied at cycle %0d, reads seen %0d", name, abort_cyc, rd_cnt);
    end else begin
      checks++;
      if (!finished) begin
        errors++;
        $display("FAIL %s timeout: got no completion within 3000 cycles, need done", name);
      end
      checks++;
      if (rd_cnt != N_WORDS || wr_cnt != N_WORDS || res_cnt != N_RESULTS || done_cnt != 1) begin
        errors++;
        $display("FAIL %s totals: got reads=%0d writes=%0d results=%0d dones=%0d, need %0d %0d %0d 1",
                 name, rd_cnt, wr_cnt, res_cnt, done_cnt, N_WORDS, N_WORDS, N_RESULTS);
      end
      checks++;
      if (seen_done != 193 + lat + N_RESULTS + nstall) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d, need %0d", name, seen_done, 193 + lat + N_RESULTS + nstall);
      end
      $display("run %s: lat=%0d stalls=%0d done at cycle %0d", name, lat, nstall, seen_done);
    end
  endtask

  task automatic test_reset();
    logic [35:0] v1, v2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    v1 = {bus1.busy, bus1.done, bus1.enable_read, bus1.read_addr, bus1.wr_valid, bus1.row_addr,
          bus1.col_addr, bus1.cha_addr, bus1.data_rdy, bus1.proc_valid, bus1.proc_dir,
          bus1.proc_counter, bus1.out_row, bus1.out_col};
    v2 = {bus2.busy, bus2.done, bus2.enable_read, bus2.read_addr, bus2.wr_valid, bus2.row_addr,
          bus2.col_addr, bus2.cha_addr, bus2.data_rdy, bus2.proc_valid, bus2.proc_dir,
          bus2.proc_counter, bus2.out_row, bus2.out_col};
    checks++;
    if (v1 !== 36'b0 || v2 !== 36'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h / %h, need 0 / 0", v1, v2);
    end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus1.busy, bus1.enable_read, bus1.wr_valid, bus1.done, bus1.proc_valid,
           bus2.busy, bus2.enable_read, bus2.wr_valid, bus2.done, bus2.proc_valid} !== 10'b0) begin
        errors++;
        $display("FAIL idle_after_reset: got activity at idle cycle %0d, need none", k);
      end
    end
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic test_full_run();        run_op(1'b0, 0, 0, 0, 0, "full_lat1");       endtask
  task automatic test_alignment_lat2();  run_op(1'b1, 0, 0, 0, 0, "align_lat2");      endtask
  task automatic test_stall();           run_op(1'b0, 1, 0, 0, 0, "stall5");          endtask
  task automatic test_ignored_start();   run_op(1'b0, 0, 50, 250, 0, "ignored_start"); endtask
  task automatic test_random_stall();
    run_op(1'b0, 2, 0, 0, 0, "rand_stall_lat1");
    run_op(1'b1, 2, 0, 0, 0, "rand_stall_lat2");
  endtask
  task automatic test_reset_mid_load();
    run_op(1'b0, 0, 0, 0, 100, "abort_load");
    run_op(1'b0, 0, 0, 0, 0, "after_abort");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 1'b0;
    start_drv = 1'b0;
    stall_drv = 1'b0;
    rst = 1'b0;
    test_reset();
    test_full_run();
    test_alignment_lat2();
    test_stall();
    test_ignored_start();
    test_random_stall();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2_scheduler.md
Name: s2_scheduler

Overview:
- Sequencer for the stage-2 convolution datapath.
- On a `start` pulse it streams the 8x8x3 input tensor (192 words) out of the stage-1 result BRAM and drives the tensor-builder write coordinates, aligned to BRAM read latency.
- It then steps the 4 filters across all 6x6 valid output positions, producing 144 results, and pulses `done`.
- It replaces the ad-hoc load/process control pair in etapa2 with one FSM that has explicit handshakes.

Parameters:
- ROWS, 8, input tensor rows.
- COLS, 8, input tensor columns.
- CHANS, 3, input channels.
- K, 3, filter kernel size (output grid is (ROWS-K+1) x (COLS-K+1) = 6x6).
- NFILT, 4, number of filters.
- BRAM_LAT, 1, BRAM read latency in cycles (1 or 2 supported).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: stage-1 data complete in BRAM.
- proc_stall  in  1  downstream cannot accept a result this cycle.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last result.
- enable_read  out  1  BRAM read enable.
- read_addr  out  8  BRAM address {cha[1:0], row[2:0], col[2:0]}.
- wr_valid  out  1  tensor-builder write strobe, aligned to BRAM data.
- row_addr  out  3  tensor row for the current write.
- col_addr  out  3  tensor column for the current write.
- cha_addr  out  2  tensor channel for the current write.
- data_rdy  out  1  tensor fully loaded; level, cleared on the next start.
- proc_valid  out  1  current (proc_dir, proc_counter) is a valid result slot.
- proc_dir  out  2  filter select, 0..3.
- proc_counter  out  6  output position index, 0..35.
- out_row  out  3  output row, 0..5.
- out_col  out  3  output column, 0..5.

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE; all counters are 0; every output is 0.
- States: IDLE, LOAD, DRAIN, CONV, DONE.
- IDLE:
  - start=1 moves to LOAD next cycle and clears data_rdy.
  - start in any other state is ignored.
- LOAD:
  - enable_read=1 every cycle.
  - read_addr walks 0..191: col fastest, then row, then channel.
  - After read_addr=191 is issued, go to DRAIN.
- Write alignment:
  - read coordinates pass through a BRAM_LAT-deep shift register to form row/col/cha_addr.
  - wr_valid is asserted exactly BRAM_LAT cycles after each enable_read.
- DRAIN:
  - enable_read=0; stay BRAM_LAT cycles until the last wr_valid has been emitted.
  - Then set data_rdy=1 and go to CONV.
- CONV:
  - proc_valid=1 whenever proc_stall=0.
  - proc_counter increments on each non-stalled cycle.
  - out_col increments and wraps 5→0, carrying into out_row; no divider.
  - At proc_counter=35 (non-stalled): counter, out_row and out_col go to 0 and proc_dir increments.
  - proc_dir=3 with proc_counter=35 accepted → DONE.
  - proc_stall=1: proc_valid=0 and all indices hold.
- DONE: done=1 for one cycle, busy=1; then IDLE. data_rdy stays 1.
- Timing with no stalls, BRAM_LAT=1, start sampled at cycle 0:
  - first enable_read at cycle 1; last at cycle 192.
  - DRAIN at cycle 193; first proc_valid at cycle 194.
  - last proc_valid at cycle 337; done at cycle 338.
- Every cycle stall is asserted in CONV adds one cycle to done.
- Reset mid-operation: immediate return to IDLE; no done pulse; data_rdy=0.
- Widths: all counters are unsigned and sized exactly; no arithmetic wraps beyond the stated ranges.

Decomposition:
- Package s2_pkg: state enum; localparams ROWS, COLS, CHANS, K, NFILT, OUT_DIM=ROWS-K+1, N_WORDS=ROWS*COLS*CHANS, N_RESULTS=NFILT*OUT_DIM*OUT_DIM; address-packing function.
- Sub-module s2_lat_pipe: BRAM_LAT-deep shift register carrying {valid, row, col, cha}.

Test Plan:
- Reset check: hold rst=0 for 3 cycles → all outputs 0 and busy=0; release and stay idle → no activity.
- Full run, BRAM_LAT=1, no stall: start at cycle 0 → 192 reads with addresses 0..191 in order; done at cycle 338; exactly 144 proc_valid cycles, each (proc_dir, proc_counter) pair appearing once.
- Alignment: BRAM model returns addr+1000 → on every wr_valid, {cha,row,col} equals the data minus 1000; repeat with BRAM_LAT=2.
- Stall: proc_stall=1 for 5 cycles at proc_dir=1, proc_counter=20 → indices hold and proc_valid=0; done at cycle 343.
- Ignored start: extra start pulses at cycles 50 and 250 → timing identical to the no-stall run; single done pulse.
- Reset mid-LOAD: assert rst at cycle 100 → IDLE immediately, data_rdy=0, no done; a new start then gives a clean full run.
